// File: rtl/conv2x2_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv2x2_window_gen.
// The master side drives pixels and window_ready; the slave side is the window generator.
interface conv2x2_window_gen_if;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] win_data;
  logic        win_valid;
  logic        win_ready;
  logic        win_last;

  modport master (
    output in_data, in_sof, in_valid, win_ready,
    input  in_ready, win_data, win_valid, win_last
  );

  modport slave (
    input  in_data, in_sof, in_valid, win_ready,
    output in_ready, win_data, win_valid, win_last
  );
endinterface

// File: rtl/conv2x2_window_gen.sv
// 2x2 window generator: one-row line buffer plus a single registered window output.
// Define CONV2X2_ZERO_PAD_EN to emit a zero-padded window for every accepted pixel.
module conv2x2_window_gen #(
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv2x2_window_gen_if.slave  px_if
);

  localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  // Byte layout of the convolution stage input register, MSB first.
  typedef struct packed {
    logic [7:0] br;
    logic [7:0] bl;
    logic [7:0] tr;
    logic [7:0] tl;
  } win_t;

  logic [COL_W-1:0] col_q, col_d, eff_col_c;
  logic [ROW_W-1:0] row_q, row_d, eff_row_c;
  logic [7:0]       prev_top_q, prev_top_d;
  logic [7:0]       prev_cur_q, prev_cur_d;
  logic [7:0]       lb_q [IMG_WIDTH];
  logic [7:0]       above_c;
  win_t             win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             in_ready_c, accept_c, load_c;

  assign px_if.in_ready  = in_ready_c;
  assign px_if.win_data  = win_q;
  assign px_if.win_valid = win_valid_q;
  assign px_if.win_last  = win_last_q;

  // A sof pixel restarts the frame at (0,0) whatever the counters hold.
  always_comb begin
    in_ready_c = !win_valid_q || px_if.win_ready;
    accept_c   = px_if.in_valid && in_ready_c;
    eff_col_c  = px_if.in_sof ? '0 : col_q;
    eff_row_c  = px_if.in_sof ? '0 : row_q;
    above_c    = lb_q[eff_col_c];
`ifdef CONV2X2_ZERO_PAD_EN
    load_c     = accept_c;
`else
    load_c     = accept_c && (eff_row_c != '0) && (eff_col_c != '0);
`endif
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    prev_top_d  = prev_top_q;
    prev_cur_d  = prev_cur_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;

    if (win_valid_q && px_if.win_ready) begin
      win_valid_d = 1'b0;
    end

    if (accept_c) begin
      prev_top_d = above_c;
      prev_cur_d = px_if.in_data;
      if (eff_col_c == COL_LAST) begin
        col_d = '0;
        row_d = (eff_row_c == ROW_LAST) ? '0 : eff_row_c + ROW_W'(1);
      end else begin
        col_d = eff_col_c + COL_W'(1);
        row_d = eff_row_c;
      end
    end

    if (load_c) begin
      win_d.br    = px_if.in_data;
`ifdef CONV2X2_ZERO_PAD_EN
      win_d.bl    = (eff_col_c == '0) ? 8'h00 : prev_cur_q;
      win_d.tr    = (eff_row_c == '0) ? 8'h00 : above_c;
      win_d.tl    = ((eff_col_c == '0) || (eff_row_c == '0)) ? 8'h00 : prev_top_q;
`else
      win_d.bl    = prev_cur_q;
      win_d.tr    = above_c;
      win_d.tl    = prev_top_q;
`endif
      win_valid_d = 1'b1;
      win_last_d  = (eff_row_c == ROW_LAST) && (eff_col_c == COL_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      prev_top_q  <= '0;
      prev_cur_q  <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      prev_top_q  <= prev_top_d;
      prev_cur_q  <= prev_cur_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  // Line buffer needs no reset: a slot is always written before it forms part of a window.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      lb_q[eff_col_c] <= px_if.in_data;
    end
  end

endmodule

// File: tb/tb_conv2x2_window_gen.sv
// Directed bench for conv2x2_window_gen at 4x3; expectations follow CONV2X2_ZERO_PAD_EN.
module tb_conv2x2_window_gen;

  localparam int unsigned W = 4;
  localparam int unsigned H = 3;
`ifdef CONV2X2_ZERO_PAD_EN
  localparam int N_WIN  = 12;
  localparam int N_PART = 6;
  localparam logic [31:0] EXP_TAB [12] = '{
    32'h01000000, 32'h02010000, 32'h03020000, 32'h04030000,
    32'h05000100, 32'h06050201, 32'h07060302, 32'h08070403,
    32'h09000500, 32'h0A090605, 32'h0B0A0706, 32'h0C0B0807};
  localparam int COMP_IDX [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
`else
  localparam int N_WIN  = 6;
  localparam int N_PART = 1;
  localparam logic [31:0] EXP_TAB [6] = '{
    32'h06050201, 32'h07060302, 32'h08070403,
    32'h0A090605, 32'h0B0A0706, 32'h0C0B0807};
  localparam int COMP_IDX [6] = '{5, 6, 7, 9, 10, 11};
`endif

  logic clk;
  logic rst_n;
  conv2x2_window_gen_if bus ();

  conv2x2_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .px_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] got_data [$];
  logic        got_last [$];
  int          got_cyc  [$];
  int          acc_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are sampled mid-cycle; they complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
      if (bus.win_valid && bus.win_ready) begin
        got_data.push_back(bus.win_data);
        got_last.push_back(bus.win_last);
        got_cyc.push_back(cyc);
      end
    end
  end

  // Table is for a frame of 1..12; nonzero bytes shift with the frame's base value.
  function automatic logic [31:0] exp_word(input int k, input int base);
    logic [31:0] w;
    w = EXP_TAB[k];
    for (int b = 0; b < 4; b++)
      if (w[8*b +: 8] != 8'h00) w[8*b +: 8] = 8'(int'(w[8*b +: 8]) + base - 1);
    return w;
  endfunction

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic drive_pixel(input logic [7:0] d, input logic s);
    int n;
    bus.in_data  = d;
    bus.in_sof   = s;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL pixel_accept_timeout data=%0d in_ready=0 want 1", d);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n, input logic first_sof);
    for (int i = 0; i < n; i++) drive_pixel(8'(base + i), first_sof && (i == 0));
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.win_valid !== 1'b0) begin n_err++; $display("FAIL reset_win_valid got %b want 0", bus.win_valid); end
    n_cmp++; if (bus.win_last !== 1'b0) begin n_err++; $display("FAIL reset_win_last got %b want 0", bus.win_last); end
    n_cmp++; if (bus.win_data !== 32'h0) begin n_err++; $display("FAIL reset_win_data got %h want 00000000", bus.win_data); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_stream();
    @(posedge clk); #1;
    clear_q();
    send_frame(1, 12, 1'b1);
    drain();
    n_cmp++; if (got_data.size() != N_WIN) begin n_err++; $display("FAIL stream_count got %0d want %0d", got_data.size(), N_WIN); end
    for (int k = 0; k < N_WIN && k < got_data.size(); k++) begin
      n_cmp++; if (got_data[k] !== exp_word(k, 1)) begin n_err++; $display("FAIL stream_data[%0d] got %h want %h", k, got_data[k], exp_word(k, 1)); end
      n_cmp++; if (got_last[k] !== (k == N_WIN - 1)) begin n_err++; $display("FAIL stream_last[%0d] got %b want %b", k, got_last[k], k == N_WIN - 1); end
      if (acc_cyc.size() == 12) begin
        n_cmp++; if (got_cyc[k] != acc_cyc[COMP_IDX[k]] + 1) begin n_err++; $display("FAIL stream_latency[%0d] got cycle %0d want %0d", k, got_cyc[k], acc_cyc[COMP_IDX[k]] + 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    clear_q();
    bus.win_ready = 1'b0;
    fork
      send_frame(1, 12, 1'b1);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.win_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        n_cmp++; if (!bus.win_valid) begin n_err++; $display("FAIL stall_wait win_valid=0 want 1"); end
        for (int i = 0; i < 5; i++) begin
          n_cmp++; if (bus.win_data !== exp_word(0, 1)) begin n_err++; $display("FAIL stall_data[%0d] got %h want %h", i, bus.win_data, exp_word(0, 1)); end
          n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, bus.in_ready); end
          @(negedge clk);
        end
        @(posedge clk); #1;
        bus.win_ready = 1'b1;
      end
    join
    drain();
    n_cmp++; if (acc_cyc.size() != 12) begin n_err++; $display("FAIL stall_pixels got %0d want 12", acc_cyc.size()); end
    n_cmp++; if (got_data.size() != N_WIN) begin n_err++; $display("FAIL stall_count got %0d want %0d", got_data.size(), N_WIN); end
    for (int k = 0; k < N_WIN && k < got_data.size(); k++) begin
      n_cmp++; if (got_data[k] !== exp_word(k, 1)) begin n_err++; $display("FAIL stall_win[%0d] got %h want %h", k, got_data[k], exp_word(k, 1)); end
      n_cmp++; if (got_last[k] !== (k == N_WIN - 1)) begin n_err++; $display("FAIL stall_last[%0d] got %b want %b", k, got_last[k], k == N_WIN - 1); end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    clear_q();
    send_frame(1, 12, 1'b1);
    send_frame(101, 12, 1'b1);
    drain();
    n_cmp++; if (got_data.size() != 2 * N_WIN) begin n_err++; $display("FAIL b2b_count got %0d want %0d", got_data.size(), 2 * N_WIN); end
    for (int k = 0; k < 2 * N_WIN && k < got_data.size(); k++) begin
      int j, base;
      j    = k % N_WIN;
      base = (k < N_WIN) ? 1 : 101;
      n_cmp++; if (got_data[k] !== exp_word(j, base)) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", k, got_data[k], exp_word(j, base)); end
      n_cmp++; if (got_last[k] !== (j == N_WIN - 1)) begin n_err++; $display("FAIL b2b_last[%0d] got %b want %b", k, got_last[k], j == N_WIN - 1); end
    end
  endtask

  task automatic test_mid_sof();
    @(posedge clk); #1;
    clear_q();
    send_frame(1, 6, 1'b1);
    send_frame(21, 12, 1'b1);
    drain();
    n_cmp++; if (got_data.size() != N_PART + N_WIN) begin n_err++; $display("FAIL midsof_count got %0d want %0d", got_data.size(), N_PART + N_WIN); end
    for (int k = 0; k < N_PART + N_WIN && k < got_data.size(); k++) begin
      logic [31:0] ew;
      logic        el;
      ew = (k < N_PART) ? exp_word(k, 1) : exp_word(k - N_PART, 21);
      el = (k == N_PART + N_WIN - 1);
      n_cmp++; if (got_data[k] !== ew) begin n_err++; $display("FAIL midsof_data[%0d] got %h want %h", k, got_data[k], ew); end
      n_cmp++; if (got_last[k] !== el) begin n_err++; $display("FAIL midsof_last[%0d] got %b want %b", k, got_last[k], el); end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    send_frame(1, 6, 1'b1);
    bus.win_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.win_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_valid got %b want 1", bus.win_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.win_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_async_valid got %b want 0", bus.win_valid); end
    n_cmp++; if (bus.win_data !== 32'h0) begin n_err++; $display("FAIL rstmid_async_data got %h want 00000000", bus.win_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.win_ready = 1'b1;
    clear_q();
    send_frame(1, 12, 1'b0);
    drain();
    n_cmp++; if (got_data.size() != N_WIN) begin n_err++; $display("FAIL rstmid_count got %0d want %0d", got_data.size(), N_WIN); end
    for (int k = 0; k < N_WIN && k < got_data.size(); k++) begin
      n_cmp++; if (got_data[k] !== exp_word(k, 1)) begin n_err++; $display("FAIL rstmid_data[%0d] got %h want %h", k, got_data[k], exp_word(k, 1)); end
      n_cmp++; if (got_last[k] !== (k == N_WIN - 1)) begin n_err++; $display("FAIL rstmid_last[%0d] got %b want %b", k, got_last[k], k == N_WIN - 1); end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_sof    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_mid_sof();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
